// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache: geometry, address/frame layouts, FSM states.
package icache_dm_pkg;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icache_addr_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {IC_IDLE, IC_FETCH} icache_state_t;
endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side port bundle of the instruction cache.
interface icache_if;
  import icache_dm_pkg::*;

  logic  dp_iREN;
  word_t dp_iaddr;
  logic  dp_flush;
  logic  dp_ihit;
  word_t dp_imemload;
  logic  mem_iREN;
  word_t mem_iaddr;
  logic  mem_iwait;
  word_t mem_iload;

  modport cache (
    input  dp_iREN, dp_iaddr, dp_flush, mem_iwait, mem_iload,
    output dp_ihit, dp_imemload, mem_iREN, mem_iaddr
  );
  modport dp (
    output dp_iREN, dp_iaddr, dp_flush,
    input  dp_ihit, dp_imemload
  );
  modport mem (
    input  mem_iREN, mem_iaddr,
    output mem_iwait, mem_iload
  );
endinterface

// File: rtl/icache_dm_frame_array.sv
// Frame storage: combinational read, clocked write; only the valid bits are reset or flushed.
module icache_frame_array
  import icache_dm_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int TAG_W = 30 - $clog2(SETS)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    flush,
  input  logic                    wen,
  input  logic [$clog2(SETS)-1:0] widx,
  input  logic [TAG_W-1:0]        wtag,
  input  word_t                   wdata,
  input  logic [$clog2(SETS)-1:0] ridx,
  output logic                    rvalid,
  output logic [TAG_W-1:0]        rtag,
  output word_t                   rdata
);
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS];

  // A flush coinciding with a fill leaves the freshly written line invalid.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else begin
      if (flush) valid <= '0;
      if (wen)   valid[widx] <= ~flush;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: same-cycle hits, blocking miss fill.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_if.cache          cif,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state, next_state;
  word_t            miss_addr;
  word_t            req_addr;
  logic             hit, miss, fill;
  logic             fvalid;
  logic [TAG_W-1:0] ftag;
  word_t            fdata;

  assign req_addr = cif.dp_iaddr & 32'hFFFF_FFFC;

  icache_frame_array #(.SETS(SETS), .TAG_W(TAG_W)) frames (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (cif.dp_flush),
    .wen   (fill),
    .widx  (miss_addr[IDX_W+1:2]),
    .wtag  (miss_addr[31:IDX_W+2]),
    .wdata (cif.mem_iload),
    .ridx  (req_addr[IDX_W+1:2]),
    .rvalid(fvalid),
    .rtag  (ftag),
    .rdata (fdata)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state      <= IC_IDLE;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (hit)  hit_count <= hit_count + CNT_W'(1);
      if (miss) begin
        miss_count <= miss_count + CNT_W'(1);
        miss_addr  <= req_addr;
      end
    end
  end

  // While a fill is in flight the datapath address is ignored; it is re-looked-up in IDLE.
  always_comb begin
    next_state      = state;
    hit             = 1'b0;
    miss            = 1'b0;
    fill            = 1'b0;
    cif.dp_ihit     = 1'b0;
    cif.dp_imemload = '0;
    cif.mem_iREN    = 1'b0;
    unique case (state)
      IC_IDLE: begin
        hit  = cif.dp_iREN & fvalid & (ftag == req_addr[31:IDX_W+2]) & ~cif.dp_flush;
        miss = cif.dp_iREN & ~hit & ~cif.dp_flush;
        cif.dp_ihit     = hit;
        cif.dp_imemload = hit ? fdata : '0;
        if (miss) next_state = IC_FETCH;
      end
      IC_FETCH: begin
        cif.mem_iREN = 1'b1;
        if (!cif.mem_iwait) begin
          fill       = 1'b1;
          next_state = IC_IDLE;
        end
      end
    endcase
  end

  assign cif.mem_iaddr = miss_addr;
endmodule
